hpc3_rnd_feeder: RTL and testbench
==================================

Name: hpc3_rnd_feeder

Overview:
- Fresh-randomness source sitting directly upstream of the HPC3 masked AND gadgets.
- Expands a 64-bit seed with a leap-forward LFSR into RND_W bits per cycle.
- RND_W covers NUM_GADGETS gadgets; each gadget needs SECURITY_ORDER*(SECURITY_ORDER+1) bits (its r bus).
- Provides a seeding handshake, a warm-up phase and a valid/ready output so the gadget pipeline can stall.

Parameters:
- SECURITY_ORDER, 1, masking order of the downstream gadgets.
- NUM_GADGETS, 1, number of gadgets fed in parallel.
- WARMUP_CYCLES, 16, LFSR advance cycles after seeding before output is valid; 0 is legal.
- Derived localparam RND_W = NUM_GADGETS*SECURITY_ORDER*(SECURITY_ORDER+1).
- Elaboration error if RND_W > 64 or RND_W == 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_i  in  32  seed word.
- seed_valid_i  in  1  seed word present.
- seed_ready_o  out  1  feeder accepts seed word.
- reseed_i  in  1  one-cycle request to restart seeding.
- rnd_o  out  RND_W  randomness word. Gadget g takes bits [g*RND_W/NUM_GADGETS +: RND_W/NUM_GADGETS].
- rnd_valid_o  out  1  rnd_o holds a fresh, never-shown word.
- rnd_ready_i  in  1  consumer takes rnd_o this cycle.
- busy_o  out  1  high in SEED_LO, SEED_HI or WARMUP.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; LFSR = 64'h1; warm-up counter = 0.
  - rnd_o = 0; rnd_valid_o = 0; seed_ready_o = 0; busy_o = 0.
- LFSR: Fibonacci, 64-bit state s.
  - One step: f = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], f}.
  - One advance = RND_W consecutive steps computed combinationally in one cycle.
  - rnd_o bit k = f produced in step k of the advance (k=0 first).
- FSM states: IDLE, SEED_LO, SEED_HI, WARMUP, RUN.
  - IDLE -> SEED_LO next cycle, unconditionally.
  - SEED_LO: seed_ready_o=1; on seed_valid_i, s[31:0] <= seed_i, go to SEED_HI.
  - SEED_HI: seed_ready_o=1; on seed_valid_i, s[63:32] <= seed_i.
    - If the assembled 64-bit value is all zero, s <= 64'h1 (lock-up avoidance).
    - Go to WARMUP, or to RUN directly if WARMUP_CYCLES==0.
  - WARMUP: one advance per cycle, output discarded; counter increments.
    - After WARMUP_CYCLES advances, go to RUN.
  - RUN: rnd_valid_o=1 with registered rnd_o.
    - Entry performs one advance to load the first word.
    - When rnd_valid_o && rnd_ready_i, advance and present the next word on the following cycle: zero-bubble streaming.
    - With rnd_ready_i low, rnd_o and the LFSR hold.
- Reseed: reseed_i in any state other than IDLE/SEED_LO goes to SEED_LO next cycle.
  - rnd_valid_o drops that same next cycle; a word handshaken in the reseed cycle counts as delivered.
  - Partial seed words and warm-up progress are discarded.
- No word is ever delivered twice; no output word before a complete seed.
- rnd_o is registered; it is not cleared on leaving RUN, only rnd_valid_o is.
- seed_ready_o and rnd_valid_o are registered state decodes, never high together.

Optional Feature:
- HPC3_RND_CNT_EN defined:
  - Adds output rnd_count_o [31:0]: count of handshaken words since the last seed completion.
  - Reset 0; cleared on SEED_HI completion; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package hpc3_rnd_pkg holds:
  - state enum {IDLE, SEED_LO, SEED_HI, WARMUP, RUN};
  - LFSR_W=64;
  - tap constant 64'hD800_0000_0000_0000;
  - function rnd_width(order, gadgets).
- Sub-module hpc3_lfsr_leap: purely combinational, parameter STEPS; in s, out s_next and bits[STEPS-1:0]. Instantiated once with STEPS=RND_W.

Test Plan:
- Reset mid-RUN (rst_n low 1 cycle) -> rnd_valid_o=0 asynchronously; seed_ready_o=1 two cycles after release.
- Seed words 32'h1 then 32'h0, WARMUP_CYCLES=0, RND_W=2, rnd_ready_i=1:
  - words 1..29 = 2'b00; word 30 = 2'b10.
  - Words beyond that match a bit-serial golden model for 1000 words.
- Seed 32'h0, 32'h0 -> identical output stream to the 64'h1 seed case.
- WARMUP_CYCLES=16, any seed: rnd_valid_o rises exactly 18 cycles after SEED_HI handshake (16 warm-up, RUN entry, register); first word equals golden word 17.
- rnd_ready_i toggled pseudo-randomly -> delivered sequence equals golden stream with no gaps or repeats; rnd_o stable while stalled.
- reseed_i pulsed in RUN with handshake in the same cycle:
  - that word counted; rnd_valid_o=0 next cycle; seed_ready_o=1.
  - New stream starts from the new seed.
  - With HPC3_RND_CNT_EN, rnd_count_o resets to 0 on the new SEED_HI completion.

Source files
------------

// File: rtl/hpc3_rnd_pkg.sv
// Shared types and constants for the HPC3 randomness feeder.
// LFSR geometry, FSM encoding and the r-bus width helper.
package hpc3_rnd_pkg;

  localparam int unsigned LFSR_W = 64;

  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEED_LO,
    SEED_HI,
    WARMUP,
    RUN
  } state_e;

  function automatic int unsigned rnd_width(
    input int unsigned order,
    input int unsigned gadgets
  );
    return gadgets * order * (order + 1);
  endfunction

endpackage

// File: rtl/hpc3_lfsr_leap.sv
// Leap-forward Fibonacci LFSR: STEPS serial steps in one combinational pass.
// bits[k] is the feedback bit produced by step k.
module hpc3_lfsr_leap
  import hpc3_rnd_pkg::*;
#(
  parameter int unsigned STEPS = 2
) (
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] s_next,
  output logic [STEPS-1:0]  bits
);

  logic [LFSR_W-1:0] t;
  logic              f;

  always_comb begin
    t    = s;
    f    = 1'b0;
    bits = '0;
    for (int k = 0; k < int'(STEPS); k++) begin
      f       = ^(t & LFSR_TAPS);
      bits[k] = f;
      t       = {t[LFSR_W-2:0], f};
    end
    s_next = t;
  end

endmodule

// File: rtl/hpc3_rnd_feeder.sv
// Fresh-randomness source for HPC3 gadgets: seed, warm-up, valid/ready stream.
// Define HPC3_RND_CNT_EN to add the delivered-word counter rnd_count_o.
module hpc3_rnd_feeder
  import hpc3_rnd_pkg::*;
#(
  parameter  int unsigned SECURITY_ORDER = 1,
  parameter  int unsigned NUM_GADGETS    = 1,
  parameter  int unsigned WARMUP_CYCLES  = 16,
  localparam int unsigned RND_W =
    rnd_width(SECURITY_ORDER, NUM_GADGETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      seed_i,
  input  logic             seed_valid_i,
  output logic             seed_ready_o,
  input  logic             reseed_i,
  output logic [RND_W-1:0] rnd_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic             busy_o
`ifdef HPC3_RND_CNT_EN
  ,
  output logic [31:0]      rnd_count_o
`endif
);

  if (RND_W > LFSR_W || RND_W == 0) begin : g_bad_w
    $error("hpc3_rnd_feeder: RND_W must be 1..64");
  end

  localparam int unsigned CNT_W =
    (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] WU_LAST =
    CNT_W'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  wu_q, wu_d;

  logic [LFSR_W-1:0] leap_s;
  logic [RND_W-1:0]  leap_bits;
  logic [LFSR_W-1:0] seed_full;
  logic              reseed_ok;

  hpc3_lfsr_leap #(
    .STEPS(RND_W)
  ) u_leap (
    .s     (lfsr_q),
    .s_next(leap_s),
    .bits  (leap_bits)
  );

  assign seed_full = {seed_i, lfsr_q[31:0]};
  assign reseed_ok = reseed_i
                   && state_q != IDLE
                   && state_q != SEED_LO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_W'(1);
      rnd_q   <= '0;
      valid_q <= 1'b0;
      wu_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      wu_q    <= wu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    wu_d    = wu_q;
    unique case (state_q)
      IDLE: state_d = SEED_LO;
      SEED_LO: begin
        if (seed_valid_i) begin
          lfsr_d  = {lfsr_q[63:32], seed_i};
          state_d = SEED_HI;
        end
      end
      SEED_HI: begin
        if (seed_valid_i) begin
          // an all-zero state would lock the LFSR up
          lfsr_d  = (seed_full == '0) ? LFSR_W'(1)
                                      : seed_full;
          wu_d    = '0;
          state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        end
      end
      WARMUP: begin
        lfsr_d = leap_s;
        wu_d   = wu_q + 1'b1;
        if (wu_q == WU_LAST) state_d = RUN;
      end
      RUN: begin
        valid_d = 1'b1;
        if (!valid_q || rnd_ready_i) begin
          lfsr_d = leap_s;
          rnd_d  = leap_bits;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reseed_ok) begin
      state_d = SEED_LO;
      valid_d = 1'b0;
      wu_d    = '0;
    end
  end

  assign rnd_o        = rnd_q;
  assign rnd_valid_o  = valid_q;
  assign seed_ready_o = (state_q == SEED_LO)
                     || (state_q == SEED_HI);
  assign busy_o       = seed_ready_o
                     || (state_q == WARMUP);

`ifdef HPC3_RND_CNT_EN
  logic [31:0] cnt_q;
  logic        seed_done;
  logic        hs;

  assign seed_done = (state_q == SEED_HI)
                  && seed_valid_i && !reseed_i;
  assign hs        = valid_q && rnd_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (seed_done) begin
      cnt_q <= '0;
    end else if (hs && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign rnd_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_hpc3_rnd_feeder.sv
// Self-checking bench: two feeders (no warm-up / 16 warm-up cycles)
// against a bit-serial LFSR stream model.
module tb_hpc3_rnd_feeder;

  localparam int RW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   seed  = '0;
  logic          seed_valid = 1'b0;
  logic          reseed = 1'b0;
  logic          ready  = 1'b0;

  logic          sr [2];
  logic          v  [2];
  logic          b  [2];
  logic [RW-1:0] r  [2];
`ifdef HPC3_RND_CNT_EN
  logic [31:0]   c  [2];
`endif

  int            errors = 0;
  int            checks = 0;
  logic [63:0]   gs  [2];
  int unsigned   cnt [2];
  logic [RW-1:0] del0 [$];

  always #5 clk = ~clk;

  hpc3_rnd_feeder #(
    .SECURITY_ORDER(1),
    .NUM_GADGETS   (1),
    .WARMUP_CYCLES (0)
  ) u0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_i      (seed),
    .seed_valid_i(seed_valid),
    .seed_ready_o(sr[0]),
    .reseed_i    (reseed),
    .rnd_o       (r[0]),
    .rnd_valid_o (v[0]),
    .rnd_ready_i (ready),
    .busy_o      (b[0])
`ifdef HPC3_RND_CNT_EN
    ,
    .rnd_count_o (c[0])
`endif
  );

  hpc3_rnd_feeder #(
    .SECURITY_ORDER(1),
    .NUM_GADGETS   (1),
    .WARMUP_CYCLES (16)
  ) u16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_i      (seed),
    .seed_valid_i(seed_valid),
    .seed_ready_o(sr[1]),
    .reseed_i    (reseed),
    .rnd_o       (r[1]),
    .rnd_valid_o (v[1]),
    .rnd_ready_i (ready),
    .busy_o      (b[1])
`ifdef HPC3_RND_CNT_EN
    ,
    .rnd_count_o (c[1])
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // bit-serial reference: one word = RW single steps
  function automatic logic [RW-1:0] next_word(input int i);
    logic [RW-1:0] w;
    logic f;
    w = '0;
    for (int k = 0; k < RW; k++) begin
      f = gs[i][63] ^ gs[i][62] ^ gs[i][60] ^ gs[i][59];
      w[k] = f;
      gs[i] = {gs[i][62:0], f};
    end
    return w;
  endfunction

  task automatic cyc();
    logic          hold [2];
    logic [RW-1:0] held [2];
    logic [RW-1:0] e;
    for (int i = 0; i < 2; i++) begin
      hold[i] = v[i] && !ready && !reseed && rst_n;
      held[i] = r[i];
      if (v[i] && ready) begin
        e = next_word(i);
        chk($sformatf("word_dut%0d", i), 64'(r[i]), 64'(e));
        if (i == 0) del0.push_back(r[i]);
        if (cnt[i] != 32'hFFFF_FFFF) cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hold[i]) begin
        chk($sformatf("stall_valid%0d", i), 64'(v[i]), 64'd1);
        chk($sformatf("stall_hold%0d", i),
            64'(r[i]), 64'(held[i]));
      end
`ifdef HPC3_RND_CNT_EN
      chk($sformatf("count%0d", i), 64'(c[i]), 64'(cnt[i]));
`endif
    end
  endtask

  task automatic wait_sr();
    int n = 0;
    while (!sr[0] && n < 20) begin
      cyc();
      n++;
    end
    chk("seed_ready_wait0", 64'(sr[0]), 64'd1);
    chk("seed_ready_wait1", 64'(sr[1]), 64'd1);
  endtask

  task automatic do_seed(input logic [31:0] lo,
                         input logic [31:0] hi);
    wait_sr();
    seed = lo;
    seed_valid = 1'b1;
    cyc();
    seed = hi;
    cnt[0] = 0;
    cnt[1] = 0;
    cyc();
    seed_valid = 1'b0;
    for (int i = 0; i < 2; i++)
      gs[i] = ({hi, lo} == 64'd0) ? 64'd1 : {hi, lo};
    // the 16 warm-up advances consume words 1..16
    for (int k = 0; k < 16; k++) void'(next_word(1));
  endtask

  task automatic check_head(input string tag);
    logic [RW-1:0] acc;
    chk({tag, "_len"}, 64'(del0.size() >= 30), 64'd1);
    if (del0.size() >= 30) begin
      acc = '0;
      for (int k = 0; k < 29; k++) acc |= del0[k];
      chk({tag, "_w1to29"}, 64'(acc), 64'd0);
      chk({tag, "_w30"}, 64'(del0[29]), 64'b10);
    end
  endtask

  initial begin
    cnt[0] = 0;
    cnt[1] = 0;
    gs[0] = 64'd1;
    gs[1] = 64'd1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rnd", 64'(r[0]), 64'd0);
    chk("rst_valid", 64'(v[0]), 64'd0);
    chk("rst_sready", 64'(sr[0]), 64'd0);
    chk("rst_busy", 64'(b[0]), 64'd0);
    cyc();
    rst_n = 1'b1;
    chk("idle_sready", 64'(sr[0]), 64'd0);
    cyc();
    cyc();
    chk("sready_2cyc", 64'(sr[0]), 64'd1);
    chk("busy_seed", 64'(b[0]), 64'd1);

    ready = 1'b1;
    do_seed(32'h1, 32'h0);
    for (int n = 1; n <= 17; n++) begin
      chk($sformatf("wu_valid_c%0d", n), 64'(v[1]), 64'd0);
      if (n == 5) begin
        chk("wu_busy16", 64'(b[1]), 64'd1);
        chk("run_busy0", 64'(b[0]), 64'd0);
        chk("run_sready0", 64'(sr[0]), 64'd0);
      end
      cyc();
    end
    chk("wu_valid_c18", 64'(v[1]), 64'd1);
    for (int n = 0; n < 1100; n++) cyc();
    check_head("seed1");
    chk("seed1_1000w", 64'(del0.size() >= 1000), 64'd1);

    for (int n = 0; n < 400; n++) begin
      ready = 1'($urandom % 2);
      cyc();
    end

    ready = 1'b1;
    chk("pre_reseed_valid", 64'(v[0]), 64'd1);
    reseed = 1'b1;
    cyc();
    reseed = 1'b0;
    chk("reseed_valid0", 64'(v[0]), 64'd0);
    chk("reseed_valid16", 64'(v[1]), 64'd0);
    chk("reseed_sready", 64'(sr[0]), 64'd1);
    del0.delete();
    do_seed(32'h0, 32'h0);
    for (int n = 0; n < 40; n++) cyc();
    check_head("seed0");

    reseed = 1'b1;
    cyc();
    reseed = 1'b0;
    do_seed($urandom, $urandom);
    for (int n = 0; n < 300; n++) begin
      ready = 1'($urandom % 2);
      cyc();
    end

    ready = 1'b1;
    cyc();
    chk("pre_rst_valid", 64'(v[0]), 64'd1);
    rst_n = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    #1;
    chk("async_rst_valid0", 64'(v[0]), 64'd0);
    chk("async_rst_valid16", 64'(v[1]), 64'd0);
    chk("async_rst_rnd", 64'(r[0]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_sready", 64'(sr[0]), 64'd0);
    cyc();
    cyc();
    chk("rel_sready_2cyc", 64'(sr[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
